// File: rtl/pulse_delay_ctrl.sv
// Controller that runs a FIFO as a programmable delay line: flush, prefill to
// the configured depth, then write and read every cycle, with sticky FIFO errors.
module pulse_delay_ctrl #(
    parameter int unsigned MAX_DELAY     = 1024,
    parameter int unsigned DEFAULT_DELAY = 50,
    parameter int unsigned FLUSH_CYCLES  = 8,
    localparam int unsigned DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [DW-1:0] cfg_delay,
    input  logic          cfg_load,
    input  logic          err_clear,
    input  logic          fifo_full,
    input  logic          fifo_empty,
    output logic          fifo_rst,
    output logic          fifo_wr_en,
    output logic          fifo_rd_en,
    output logic          out_valid,
    output logic          cfg_ack,
    output logic [DW-1:0] delay_active,
    output logic [DW-1:0] fill_count,
    output logic [2:0]    state_o,
    output logic          err_overflow,
    output logic          err_underflow
);

    localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FlushLast = FW'(FLUSH_CYCLES - 1);
    localparam logic [DW-1:0] MaxDelay  = DW'(MAX_DELAY);
    localparam int unsigned ResetDelayInt = (DEFAULT_DELAY == 0) ? 1 :
        ((DEFAULT_DELAY > MAX_DELAY) ? MAX_DELAY : DEFAULT_DELAY);
    localparam logic [DW-1:0] ResetDelay = DW'(ResetDelayInt);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFlush = 3'd1,
        StFill  = 3'd2,
        StRun   = 3'd3,
        StFault = 3'd4
    } state_e;

    state_e        state_q;
    logic [FW-1:0] flush_cnt_q;
    logic [DW-1:0] fill_cnt_q;
    logic [DW-1:0] delay_q;
    logic          fifo_rst_q, wr_en_q, rd_en_q, out_valid_q, cfg_ack_q;
    logic          ovf_q, udf_q;

    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
        if (d == '0) begin
            return DW'(1);
        end else if (d > MaxDelay) begin
            return MaxDelay;
        end
        return d;
    endfunction

    // Strobe-style outputs default low each cycle; each branch re-asserts what
    // the upcoming state drives, so outputs stay aligned with state_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            fill_cnt_q  <= '0;
            delay_q     <= ResetDelay;
            fifo_rst_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_ack_q   <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            fifo_rst_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            cfg_ack_q   <= 1'b0;
            if (err_clear) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (cfg_load) begin
                        delay_q   <= clamp_delay(cfg_delay);
                        cfg_ack_q <= 1'b1;
                    end
                    if (enable && !ovf_q && !udf_q) begin
                        state_q     <= StFlush;
                        flush_cnt_q <= '0;
                        fifo_rst_q  <= 1'b1;
                    end
                end
                StFlush: begin
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if (flush_cnt_q == FlushLast) begin
                        state_q    <= StFill;
                        fill_cnt_q <= '0;
                        wr_en_q    <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FW'(1);
                        fifo_rst_q  <= 1'b1;
                    end
                end
                StFill: begin
                    if (fifo_full) begin
                        ovf_q   <= 1'b1;
                        state_q <= StFault;
                    end else if (!enable) begin
                        state_q <= StIdle;
                    end else if (fill_cnt_q == delay_q - DW'(1)) begin
                        state_q <= StRun;
                        wr_en_q <= 1'b1;
                        rd_en_q <= 1'b1;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + DW'(1);
                        wr_en_q    <= 1'b1;
                    end
                end
                StRun: begin
                    if (fifo_full || fifo_empty) begin
                        if (fifo_full) ovf_q <= 1'b1;
                        if (fifo_empty) udf_q <= 1'b1;
                        state_q <= StFault;
                    end else if (!enable) begin
                        state_q <= StIdle;
                    end else begin
                        wr_en_q     <= 1'b1;
                        rd_en_q     <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                StFault: begin
                    if (!ovf_q && !udf_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fifo_rst      = fifo_rst_q;
    assign fifo_wr_en    = wr_en_q;
    assign fifo_rd_en    = rd_en_q;
    assign out_valid     = out_valid_q;
    assign cfg_ack       = cfg_ack_q;
    assign delay_active  = delay_q;
    assign fill_count    = fill_cnt_q;
    assign state_o       = state_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = udf_q;

endmodule

// File: tb/tb_pulse_delay_ctrl.sv
// Scoreboard bench for pulse_delay_ctrl: a time-since-enable reference model
// queues expected outputs per cycle; a monitor pops and compares after each edge.
module tb_pulse_delay_ctrl;

    localparam int MAXD = 1024;
    localparam int DEFD = 50;
    localparam int FC   = 8;
    localparam int DW   = 11;

    logic          clk = 1'b0;
    logic          rst, enable, cfg_load, err_clear, fifo_full, fifo_empty;
    logic [DW-1:0] cfg_delay;
    logic          fifo_rst, fifo_wr_en, fifo_rd_en, out_valid, cfg_ack;
    logic [DW-1:0] delay_active, fill_count;
    logic [2:0]    state_o;
    logic          err_overflow, err_underflow;

    pulse_delay_ctrl #(
        .MAX_DELAY    (MAXD),
        .DEFAULT_DELAY(DEFD),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_delay    (cfg_delay),
        .cfg_load     (cfg_load),
        .err_clear    (err_clear),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_rst     (fifo_rst),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_rd_en   (fifo_rd_en),
        .out_valid    (out_valid),
        .cfg_ack      (cfg_ack),
        .delay_active (delay_active),
        .fill_count   (fill_count),
        .state_o      (state_o),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          frst;
        logic          wr;
        logic          rd;
        logic          valid;
        logic          ack;
        logic [DW-1:0] delay;
        logic [DW-1:0] fill;
        logic [2:0]    st;
        logic          ovf;
        logic          udf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cycle  = 0;

    // Reference model: mode 0 idle, 1 active, 2 fault; within active the phase
    // follows from cycles elapsed since enable was honoured.
    int m_mode, m_t, m_delay, m_fill;
    bit m_ovf, m_udf, m_ack, m_valid;

    function automatic int clampd(input int d);
        if (d == 0) return 1;
        if (d > MAXD) return MAXD;
        return d;
    endfunction

    function automatic int phase();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 4;
        if (m_t < FC) return 1;
        if (m_t < FC + m_delay) return 2;
        return 3;
    endfunction

    task automatic step(input bit r, input bit en, input bit ld, input bit clr,
                        input bit full, input bit empty, input int d);
        int   ph;
        bit   so, su, po, pu;
        exp_t e;
        @(negedge clk);
        rst = r; enable = en; cfg_load = ld; err_clear = clr;
        fifo_full = full; fifo_empty = empty; cfg_delay = DW'(d);
        if (r) begin
            m_mode = 0; m_t = 0; m_delay = clampd(DEFD); m_fill = 0;
            m_ovf = 0; m_udf = 0; m_ack = 0; m_valid = 0;
        end else begin
            ph = phase();
            so = (ph == 2 || ph == 3) && full;
            su = (ph == 3) && empty;
            po = m_ovf; pu = m_udf;
            m_ack = 0; m_valid = 0;
            if (clr) begin m_ovf = 0; m_udf = 0; end
            if (so) m_ovf = 1;
            if (su) m_udf = 1;
            case (ph)
                0: begin
                    if (ld) begin m_delay = clampd(d); m_ack = 1; end
                    if (en && !po && !pu) begin m_mode = 1; m_t = 0; end
                end
                1, 2, 3: begin
                    if (so || su) m_mode = 2;
                    else if (!en) m_mode = 0;
                    else begin
                        m_valid = (ph == 3);
                        if (m_t < FC + m_delay) m_t++;
                        if (m_t >= FC && m_t < FC + m_delay) m_fill = m_t - FC;
                    end
                end
                default: if (!po && !pu) m_mode = 0;
            endcase
        end
        ph      = phase();
        e.frst  = (ph == 1);
        e.wr    = (ph == 2 || ph == 3);
        e.rd    = (ph == 3);
        e.valid = m_valid;
        e.ack   = m_ack;
        e.delay = DW'(m_delay);
        e.fill  = DW'(m_fill);
        e.st    = 3'(ph);
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input bit en, input int n);
        repeat (n) step(0, en, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge is an output transaction of the DUT.
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a.frst = fifo_rst; a.wr = fifo_wr_en; a.rd = fifo_rd_en;
                a.valid = out_valid; a.ack = cfg_ack; a.delay = delay_active;
                a.fill = fill_count; a.st = state_o; a.ovf = err_overflow;
                a.udf = err_underflow;
                checks++;
                if (a === e) passed++;
                else $display("FAIL outputs cyc=%0d got st=%0d rst/wr/rd/v/ack=%b%b%b%b%b dly=%0d fill=%0d ovf/udf=%b%b, want st=%0d rst/wr/rd/v/ack=%b%b%b%b%b dly=%0d fill=%0d ovf/udf=%b%b",
                    cycle, a.st, a.frst, a.wr, a.rd, a.valid, a.ack, a.delay, a.fill,
                    a.ovf, a.udf, e.st, e.frst, e.wr, e.rd, e.valid, e.ack, e.delay,
                    e.fill, e.ovf, e.udf);
            end
        end
    end

    initial begin
        bit r, en, ld, clr, full, empty;
        int d;
        rst = 1'b1; enable = 1'b0; cfg_load = 1'b0; err_clear = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b0; cfg_delay = '0;

        repeat (2) step(1, 0, 0, 0, 0, 0, 0);
        idle_cycles(1, 70);                          // flush, fill of 50, run
        step(0, 1, 1, 0, 0, 0, $urandom_range(1, 30)); // load ignored in run
        idle_cycles(1, 3);
        step(0, 1, 0, 0, 0, 1, 0);                   // underflow in run
        idle_cycles(1, 3);
        step(0, 1, 0, 1, 0, 0, 0);                   // clear, then refill
        idle_cycles(1, 12);
        idle_cycles(0, 2);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 2000);
        step(0, 0, 1, 0, 0, 0, $urandom_range(2, 9));
        idle_cycles(1, 25);
        idle_cycles(0, 2);
        step(0, 0, 1, 0, 0, 0, 40);
        idle_cycles(1, 14);
        step(0, 1, 0, 1, 1, 0, 0);                   // full wins over clear in fill
        idle_cycles(1, 4);
        step(0, 1, 0, 1, 0, 0, 0);
        idle_cycles(1, 3);
        step(1, 0, 0, 0, 0, 0, 0);
        idle_cycles(1, 29);                          // reach fill_count 20
        idle_cycles(0, 1);
        idle_cycles(1, 65);
        step(1, 1, 0, 0, 0, 0, 0);                   // reset mid-run
        idle_cycles(0, 3);

        for (int i = 0; i < 900; i++) begin
            r     = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 99) < 96);
            ld    = ($urandom_range(0, 99) < 5);
            clr   = ($urandom_range(0, 99) < 8);
            full  = ($urandom_range(0, 99) < 2);
            empty = ($urandom_range(0, 99) < 3);
            d     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047)
                                                : $urandom_range(0, 12);
            step(r, en, ld, clr, full, empty, d);
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain pending=%0d want 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pulse_delay_ctrl.md
PULSE_DELAY_CTRL -- requirements
Module: pulse_delay_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_DELAY, default 1024, meaning the largest programmable delay in clk cycles.
REQ-002 The block SHALL have parameter DEFAULT_DELAY, default 50, meaning the delay loaded at reset.
REQ-003 The block SHALL have parameter FLUSH_CYCLES, default 8, meaning the number of cycles fifo_rst is held per flush.
REQ-004 The block SHALL have derived parameter DW = $clog2(MAX_DELAY+1), meaning the width of the delay and count fields.
REQ-005 The block SHALL use clock clk and reset rst; rst is synchronous and active-high.
REQ-006 The block SHALL have the following ports, one per line as name, direction, width, meaning:
 clk  in  1  system clock
 rst  in  1  synchronous active-high reset
 enable  in  1  level; 1 = run delay line
 cfg_delay  in  DW  requested delay in cycles
 cfg_load  in  1  1-cycle strobe that samples cfg_delay
 err_clear  in  1  1-cycle strobe that clears sticky errors
 fifo_full  in  1  FIFO full flag
 fifo_empty  in  1  FIFO empty flag
 fifo_rst  out  1  FIFO reset
 fifo_wr_en  out  1  FIFO write enable
 fifo_rd_en  out  1  FIFO read enable
 out_valid  out  1  FIFO dout carries valid delayed data
 cfg_ack  out  1  1-cycle pulse when cfg_load is accepted
 delay_active  out  DW  delay currently in force
 fill_count  out  DW  writes performed in FILL
 state_o  out  3  encoded state: IDLE=0, FLUSH=1, FILL=2, RUN=3, FAULT=4
 err_overflow  out  1  sticky; FIFO full seen in RUN or FILL
 err_underflow  out  1  sticky; FIFO empty seen while reading

Function
REQ-007 The FSM SHALL have states IDLE, FLUSH, FILL, RUN and FAULT, and all outputs SHALL be registered.
REQ-008 In IDLE: wr_en=0, rd_en=0, fifo_rst=0; the FSM SHALL go to FLUSH on the next edge when enable=1 and both error flags are 0.
REQ-009 In FLUSH: fifo_rst=1 for exactly FLUSH_CYCLES cycles, wr_en=0, rd_en=0; the FSM SHALL then go to FILL.
REQ-010 In FILL: wr_en=1, rd_en=0; fill_count SHALL start at 0 on entry and increment once per cycle; the FSM SHALL go to RUN on the edge after the cycle in which fill_count = delay_active-1 (exactly delay_active write cycles).
REQ-011 In RUN: wr_en=1 and rd_en=1 every cycle; fill_count SHALL hold its value.
REQ-012 out_valid SHALL be 1 in the cycle following each RUN cycle with rd_en=1 and no error detected (1-cycle FIFO read latency), and 0 otherwise.
REQ-013 cfg_load SHALL be accepted only in IDLE: delay_active <= clamp(cfg_delay) and cfg_ack=1 on the next cycle; cfg_load in any other state SHALL be ignored with cfg_ack=0.
REQ-014 Clamping: cfg_delay=0 SHALL load 1, and cfg_delay>MAX_DELAY SHALL load MAX_DELAY.
REQ-015 fifo_full=1 in FILL or RUN SHALL set err_overflow and move the FSM to FAULT on the next edge.
REQ-016 fifo_empty=1 in a RUN cycle SHALL set err_underflow and move the FSM to FAULT on the next edge.
REQ-017 In FAULT: wr_en=0, rd_en=0, out_valid=0; the FSM SHALL go to IDLE when both error flags are 0.
REQ-018 err_clear SHALL clear both error flags on the next edge; if an error condition occurs in the same cycle as err_clear, the set SHALL win.
REQ-019 enable=0 in FLUSH, FILL or RUN SHALL move the FSM to IDLE on the next edge, dropping wr_en/rd_en/out_valid; an error detected in the same cycle SHALL take priority, so the FSM goes to FAULT.
REQ-020 Re-entering FLUSH from IDLE SHALL always flush the FIFO, discarding stale data.

Reset
REQ-021 While rst=1, the block SHALL set state=IDLE, delay_active=DEFAULT_DELAY (clamped), fill_count=0, drive all 1-bit outputs to 0, and clear both error flags.
REQ-022 rst SHALL override every other input, including in mid-FILL, mid-RUN or FAULT; one cycle after release the FSM SHALL be in IDLE.

Verification
REQ-023 rst, then enable=1 with the default delay -> FLUSH for 8 cycles, FILL for 50 cycles (fill_count 0..49), rd_en rises on cycle 59 after enable, out_valid rises 1 cycle later.
REQ-024 In IDLE, cfg_load with cfg_delay=0 -> delay_active=1, cfg_ack pulse; cfg_delay=2000 -> delay_active=1024; cfg_load during RUN -> delay_active unchanged, no cfg_ack.
REQ-025 In RUN, fifo_empty=1 for 1 cycle -> err_underflow=1, FAULT, wr/rd/out_valid=0; err_clear -> IDLE; enable still 1 -> new FLUSH sequence.
REQ-026 In FILL, fifo_full=1 in the same cycle as err_clear -> err_overflow=1 remains set, FSM in FAULT.
REQ-027 enable dropped at fill_count=20 -> IDLE next cycle; re-enable -> FLUSH then full 50-cycle FILL from 0.
REQ-028 rst asserted mid-RUN for 1 cycle -> all outputs 0, delay_active=50, state_o=0 the following cycle.
